mmio_bridge: RTL

Parametrised external memory-mapped I/O bridge between the CPU's external read/write strobes and NUM_CH peripheral channels. It decodes the top address field, runs a per-access req/ack handshake with wait states, stalls the CPU until completion and times out hung peripherals. It replaces the single-cycle, zero-wait rdata/mm_re/mm_we path at the CPU top level.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_decode.sv | 22 ++
 rtl/mmio_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge: FSM state encoding, region field width,
// default error data and the channel-index width helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam int REGION_W = 3;
  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_decode.sv
// Region decode for the MMIO bridge: classifies the top address field as internal,
// mapped to a peripheral channel, or unmapped.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic [REGION_W-1:0] region,
  output logic                is_ext,
  output logic                is_mapped,
  output logic [CH_W-1:0]     ch_idx
);

  always_comb begin
    is_ext    = (region != '0);
    is_mapped = is_ext && (region <= REGION_W'(NUM_CH));
    ch_idx    = CH_W'(region - REGION_W'(1));
  end

endmodule

// File: rtl/mmio_bridge.sv
// External MMIO bridge: decodes CPU accesses onto NUM_CH req/ack channels, stalls the CPU
// until completion and times out hung peripherals. MMIO_BRIDGE_POSTED_WR_EN enables posted writes.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                NUM_CH      = 4,
  parameter int                TIMEOUT_CYC = 15,
  parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic [NUM_CH-1:0]        ch_req,
  output logic                     ch_we,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack,
  output logic                     bus_err,
  input  logic                     err_clr
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ch_idx;
  logic [TMO_W-1:0]  tmo;
  logic [DATA_W-1:0] rdata_q;
  logic              posted_q;
  logic              is_ext;
  logic              is_mapped;
  logic              ext_req;
  logic              posted_wr;
  logic              ack_sel;
  logic              tmo_hit;

  mmio_decode #(
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_decode (
    .region   (cpu_addr[ADDR_W-1 -: REGION_W]),
    .is_ext   (is_ext),
    .is_mapped(is_mapped),
    .ch_idx   (ch_idx)
  );

`ifdef MMIO_BRIDGE_POSTED_WR_EN
  assign posted_wr = cpu_we;
`else
  assign posted_wr = 1'b0;
`endif

  assign ext_req   = (cpu_re | cpu_we) & is_ext;
  assign ack_sel   = ch_ack[ch_q];
  assign tmo_hit   = (tmo == TMO_LAST);
  assign cpu_rdata = (state == DONE) ? rdata_q : '0;

  // A posted write in flight only stalls a new external access until the bridge is idle.
  always_comb begin
    cpu_stall = 1'b0;
    unique case (state)
      IDLE:    cpu_stall = ext_req && !(is_mapped && posted_wr);
      REQ:     cpu_stall = posted_q ? ext_req : 1'b1;
      DONE:    cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_req   <= '0;
      ch_we    <= 1'b0;
      ch_addr  <= '0;
      ch_wdata <= '0;
      ch_q     <= '0;
      rdata_q  <= '0;
      tmo      <= '0;
      bus_err  <= 1'b0;
      posted_q <= 1'b0;
    end else begin
      // Error sets below are later assignments and therefore win over the clear.
      if (err_clr) bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ext_req) begin
            if (cpu_re && cpu_we) bus_err <= 1'b1;
            if (is_mapped) begin
              ch_addr        <= cpu_addr;
              ch_wdata       <= cpu_wdata;
              ch_we          <= cpu_we;
              ch_q           <= ch_idx;
              ch_req         <= '0;
              ch_req[ch_idx] <= 1'b1;
              tmo            <= '0;
              posted_q       <= posted_wr;
              state          <= REQ;
            end else begin
              rdata_q <= ERR_DATA;
              bus_err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        REQ: begin
          tmo <= (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
          if (ack_sel) begin
            if (!ch_we) rdata_q <= ch_rdata[int'(ch_q)*DATA_W +: DATA_W];
            ch_req <= '0;
            state  <= posted_q ? IDLE : DONE;
          end else if (tmo_hit) begin
            if (!posted_q) rdata_q <= ERR_DATA;
            bus_err <= 1'b1;
            ch_req  <= '0;
            state   <= posted_q ? IDLE : DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
